// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: instruction memory, decode handshake, redirect and status
interface fetch_unit_if;
  logic        imemRd;
  logic [15:0] imemAddr;
  logic        imemDone;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic [15:0] pcPlus2;
  logic        instrValid;
  logic        decReady;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        halted;
  logic        err;

  modport master (
    output imemRd, imemAddr, instr, pcPlus2, instrValid, halted, err,
    input  imemDone, imemData, decReady, redirect, redirectPC
  );

  modport slave (
    input  imemRd, imemAddr, instr, pcPlus2, instrValid, halted, err,
    output imemDone, imemData, decReady, redirect, redirectPC
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with PC, 2-entry FIFO, redirect and HALT stop
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD,
    S_HALTED
  } fetchStateT;

  fetchStateT  state, stateNext;
  logic [15:0] pc, pcNext;
  logic        errReg, errNext;
  logic        reqIssue;
  logic        push, pop, flush;

  logic [15:0] fifoInstr [0:1];
  logic [15:0] fifoPc2   [0:1];
  logic        rdPtr, wrPtr;
  logic [1:0]  count;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    errNext   = errReg;
    reqIssue  = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = (count != 2'd0) && bus.decReady && !bus.redirect;

    if (bus.redirect) begin
      flush  = 1'b1;
      pcNext = bus.redirectPC;
      case (state)
        S_WAIT, S_DISCARD: stateNext = bus.imemDone ? S_REQ : S_DISCARD;
        default:           stateNext = S_REQ;
      endcase
      // A misaligned target, or any redirect after one, locks fetch until reset.
      if (bus.redirectPC[0] || errReg) begin
        errNext   = 1'b1;
        stateNext = S_HALTED;
      end
    end else begin
      case (state)
        S_REQ: begin
          if ((count != 2'd2) && !rst) begin
            reqIssue  = 1'b1;
            stateNext = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imemDone) begin
            push      = 1'b1;
            pcNext    = pc + 16'd2;
            stateNext = (bus.imemData[15:11] == 5'b00000) ? S_HALTED : S_REQ;
          end
        end
        S_DISCARD: begin
          if (bus.imemDone) stateNext = S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= 16'h0000;
      errReg <= 1'b0;
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      errReg <= errNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
    end else begin
      if (push) wrPtr <= ~wrPtr;
      if (pop)  rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoInstr[wrPtr] <= bus.imemData;
      fifoPc2[wrPtr]   <= pc + 16'd2;
    end
  end

  assign bus.imemRd     = reqIssue;
  assign bus.imemAddr   = pc;
  assign bus.instr      = fifoInstr[rdPtr];
  assign bus.pcPlus2    = fifoPc2[rdPtr];
  assign bus.instrValid = (count != 2'd0);
  assign bus.halted     = (state == S_HALTED);
  assign bus.err        = errReg;

endmodule
